// File: rtl/robot_nav.sv
// robot_nav: wall-following navigator with per-sensor debouncing, a timed-turn FSM
// and abort to STUCK after too many turns made without wall contact.
module robot_nav #(
    parameter int DEB_CYCLES  = 2,
    parameter int TURN_CYCLES = 4,
    parameter int MAX_TURNS   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       side_sel,
    input  logic       front_sensor,
    input  logic       left_sensor,
    input  logic       right_sensor,
    output logic       front,
    output logic       turn,
    output logic       turn_dir,
    output logic       stuck,
    output logic [2:0] state_o
);
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        NO_ENTRY    = 3'd1,
        WALL_ENTRY  = 3'd2,
        FRONT_ENTRY = 3'd3,
        CORNER      = 3'd4,
        STUCK       = 3'd5
    } state_t;

    state_t     state, tgt, state_nx;
    logic [2:0] raw, filt;
    logic [7:0] timer;
    logic [3:0] turn_cnt, cnt_eff;
    logic       side, f, w, timer_done, entering, to_stuck;

    assign raw = {front_sensor, left_sensor, right_sensor};

    for (genvar g = 0; g < 3; g++) begin : g_deb
        logic [7:0] cnt;
        logic       q;
        always_ff @(posedge clk)
            if (reset) begin
                q   <= 1'b0;
                cnt <= 8'd0;
            end else if (raw[g] == q) begin
                cnt <= 8'd0;
            end else if (cnt == 8'(DEB_CYCLES - 1)) begin
                q   <= ~q;
                cnt <= 8'd0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        assign filt[g] = q;
    end

    assign f          = filt[2];
    assign w          = side ? filt[0] : filt[1];
    assign timer_done = timer == 8'(TURN_CYCLES - 1);
    // WALL_ENTRY continuously clears the turn count, so a turn leaving it starts from zero
    assign cnt_eff    = state == WALL_ENTRY ? 4'd0 : turn_cnt;

    always_comb begin
        tgt = state;
        case (state)
            IDLE:        tgt = NO_ENTRY;
            NO_ENTRY:    tgt = f ? FRONT_ENTRY : w ? WALL_ENTRY : NO_ENTRY;
            WALL_ENTRY:  tgt = (f && w) ? FRONT_ENTRY : w ? WALL_ENTRY : CORNER;
            FRONT_ENTRY: tgt = (!timer_done || f) ? FRONT_ENTRY : w ? WALL_ENTRY : NO_ENTRY;
            CORNER:      tgt = timer_done ? NO_ENTRY : CORNER;
            STUCK:       tgt = STUCK;
            default:     tgt = IDLE;
        endcase
    end

    assign entering = (tgt == FRONT_ENTRY || tgt == CORNER) && tgt != state;
    assign to_stuck = entering && cnt_eff == 4'(MAX_TURNS - 1);
    assign state_nx = !enable ? IDLE : to_stuck ? STUCK : tgt;

    always_ff @(posedge clk)
        if (reset) begin
            state    <= IDLE;
            timer    <= 8'd0;
            turn_cnt <= 4'd0;
            side     <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && enable)
                side <= side_sel;
            if (!enable) begin
                timer    <= 8'd0;
                turn_cnt <= 4'd0;
            end else if (entering && !to_stuck) begin
                timer    <= 8'd0;
                turn_cnt <= cnt_eff + 4'd1;
            end else begin
                timer    <= timer_done ? timer : timer + 8'd1;
                turn_cnt <= cnt_eff;
            end
        end

    assign front    = state == NO_ENTRY || state == WALL_ENTRY;
    assign turn     = state == FRONT_ENTRY || state == CORNER;
    assign turn_dir = state == FRONT_ENTRY ? ~side : state == CORNER ? side : 1'b0;
    assign stuck    = state == STUCK;
    assign state_o  = state;
endmodule

// File: tb/tb_robot_nav.sv
// tb_robot_nav: directed stimulus against a cycle-level behavioural model,
// compared every cycle, plus hand-computed literal checkpoints.
module tb_robot_nav;
    localparam int DEB = 2, TURN = 4, MAXT = 3;

    logic clk = 0, reset = 1, enable = 0, side_sel = 0;
    logic front_sensor = 0, left_sensor = 0, right_sensor = 0;
    logic front, turn, turn_dir, stuck;
    logic [2:0] state_o;

    int checks = 0, errors = 0;
    int m_st = 0, m_age = 0, m_turns = 0, m_side = 0;
    int m_filt[3] = '{0, 0, 0};
    int m_run[3]  = '{0, 0, 0};
    bit started = 0;

    robot_nav #(.DEB_CYCLES(DEB), .TURN_CYCLES(TURN), .MAX_TURNS(MAXT)) dut (
        .clk(clk), .reset(reset), .enable(enable), .side_sel(side_sel),
        .front_sensor(front_sensor), .left_sensor(left_sensor), .right_sensor(right_sensor),
        .front(front), .turn(turn), .turn_dir(turn_dir), .stuck(stuck), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: index 0 front, 1 left, 2 right; m_age counts cycles since entering a turn.
    always @(posedge clk) begin : model
        int fv, wv, nxt;
        int rv[3];
        if (reset) begin
            m_st = 0; m_age = 0; m_turns = 0; m_side = 0;
            m_filt = '{0, 0, 0};
            m_run = '{0, 0, 0};
            started = 1;
        end else begin
            fv = m_filt[0];
            wv = m_side != 0 ? m_filt[2] : m_filt[1];
            nxt = m_st;
            if (!enable) begin
                nxt = 0;
                m_turns = 0;
            end else begin
                case (m_st)
                    0: begin nxt = 1; m_side = int'(side_sel); end
                    1: nxt = fv != 0 ? 3 : wv != 0 ? 2 : 1;
                    2: begin m_turns = 0; nxt = (fv != 0 && wv != 0) ? 3 : wv != 0 ? 2 : 4; end
                    3: nxt = (m_age < TURN - 1 || fv != 0) ? 3 : wv != 0 ? 2 : 1;
                    4: nxt = m_age < TURN - 1 ? 4 : 1;
                    default: nxt = 5;
                endcase
                if ((nxt == 3 || nxt == 4) && nxt != m_st) begin
                    if (m_turns + 1 >= MAXT) nxt = 5;
                    else begin m_turns++; m_age = 0; end
                end else m_age++;
            end
            m_st = nxt;
            rv[0] = int'(front_sensor); rv[1] = int'(left_sensor); rv[2] = int'(right_sensor);
            for (int i = 0; i < 3; i++) begin
                if (rv[i] == m_filt[i]) m_run[i] = 0;
                else begin
                    m_run[i]++;
                    if (m_run[i] >= DEB) begin m_filt[i] = 1 - m_filt[i]; m_run[i] = 0; end
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        logic ef, et, ed, es;
        if (started) begin
            ef = m_st == 1 || m_st == 2;
            et = m_st == 3 || m_st == 4;
            ed = m_st == 3 ? m_side == 0 : m_st == 4 ? m_side != 0 : 1'b0;
            es = m_st == 5;
            check("model_outputs", {25'd0, state_o, front, turn, turn_dir, stuck},
                  {25'd0, 3'(m_st), ef, et, ed, es});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        tick(2);
        reset = 0;
        check("reset_state", state_o, 0);
        check("reset_outputs", {front, turn, turn_dir, stuck}, 0);
        enable = 1;
        tick(1);
        check("enable_no_entry", state_o, 1);
        check("enable_front", front, 1);
        front_sensor = 1; tick(1); front_sensor = 0; tick(3);
        check("pulse_ignored", {state_o, front}, {3'd1, 1'b1});
        front_sensor = 1; tick(2);
        check("front_hold_2", state_o, 1);
        tick(1);
        check("front_hold_3", state_o, 3);
        check("front_turn_dir", {turn, turn_dir}, 2'b11);
        front_sensor = 0; tick(8);
        check("front_release", state_o, 1);
        left_sensor = 1; tick(3);
        check("wall_entry", state_o, 2);
        front_sensor = 1; tick(2); front_sensor = 0; tick(1);
        check("wall_front", {state_o, turn, turn_dir}, {3'd3, 2'b11});
        tick(3);
        check("front_dwell", state_o, 3);
        tick(1);
        check("back_to_wall", state_o, 2);
        enable = 0; tick(1);
        check("idle_outputs", {state_o, front, turn, turn_dir, stuck}, 0);
        side_sel = 1; right_sensor = 1; left_sensor = 0; enable = 1;
        tick(3);
        check("right_wall", state_o, 2);
        right_sensor = 0; tick(3);
        check("corner", {state_o, turn, turn_dir}, {3'd4, 2'b11});
        tick(3);
        check("corner_dwell", state_o, 4);
        tick(1);
        check("corner_exit", state_o, 1);
        front_sensor = 1; tick(3);
        check("turn2", {state_o, turn_dir}, {3'd3, 1'b0});
        front_sensor = 0; tick(8);
        check("turn2_exit", state_o, 1);
        front_sensor = 1; tick(3);
        check("stuck", {state_o, stuck}, {3'd5, 1'b1});
        front_sensor = 0; tick(3);
        check("stuck_hold", {state_o, front, turn, stuck}, {3'd5, 3'b001});
        enable = 0; tick(1);
        check("stuck_to_idle", state_o, 0);
        enable = 1; tick(1);
        front_sensor = 1; tick(3);
        check("turn_again", state_o, 3);
        enable = 0; tick(1);
        check("drop_in_turn", {state_o, front, turn, turn_dir, stuck}, 0);
        enable = 1; tick(2);
        check("reenable_turn1", state_o, 3);
        front_sensor = 0; tick(8);
        front_sensor = 1; tick(3);
        check("count_restarted", state_o, 3);
        reset = 1; tick(1);
        check("reset_mid_turn", {state_o, front, turn, turn_dir, stuck}, 0);
        reset = 0; tick(2);
        check("filter_cleared", state_o, 1);
        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
